// File: rtl/instruction_fetch_unit_pkg.sv
// +----------------------------------------------------------------------+
// | instruction_fetch_unit_pkg: shared fetch constants and state coding  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package instruction_fetch_unit_pkg;

    localparam logic [31:0] c_NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_holding_register.sv
// +----------------------------------------------------------------------+
// | fetch_holding_register: one-entry buffer for a stalled fetch result  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module fetch_holding_register (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        clear_i,
    input  logic [31:0] data_i,
    input  logic [31:0] pc_4_i,
    output logic [31:0] data_o,
    output logic [31:0] pc_4_o,
    output logic        valid_o
);

    logic [31:0] data_q;
    logic [31:0] pc_4_q;
    logic        valid_q;

    // Clear (flush) wins over a load in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_4_q  <= '0;
        end else if (clear_i || drain_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            pc_4_q  <= pc_4_i;
        end
    end

    assign data_o  = data_q;
    assign pc_4_o  = pc_4_q;
    assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// +----------------------------------------------------------------------+
// | instruction_fetch_unit: single-outstanding fetch with stall/redirect |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter logic [31:0] NOP_WORD = c_NOP_WORD
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc_4,
    output logic [31:0] if_instruction
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  target_q;
    logic         if_valid_q;
    logic [31:0]  if_pc_4_q;
    logic [31:0]  if_instruction_q;

    logic [31:0]  w_pc_plus4;
    logic         w_slot_free;
    logic         w_hold_load;
    logic         w_hold_drain;
    logic [31:0]  w_hold_data;
    logic [31:0]  w_hold_pc_4;
    logic         w_hold_valid;

    assign w_pc_plus4   = pc_q + 32'd4;
    assign w_slot_free  = !if_valid_q || !id_stall;
    assign w_hold_load  = !redirect_valid && (state_q == FETCH) && imem_ack && !w_slot_free;
    assign w_hold_drain = !redirect_valid && (state_q == HOLD) && !id_stall;

    fetch_holding_register u_holding (
        .clock   (clock),
        .reset   (reset),
        .load_i  (w_hold_load),
        .drain_i (w_hold_drain),
        .clear_i (redirect_valid),
        .data_i  (imem_rdata),
        .pc_4_i  (w_pc_plus4),
        .data_o  (w_hold_data),
        .pc_4_o  (w_hold_pc_4),
        .valid_o (w_hold_valid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= FETCH;
            pc_q             <= RESET_PC;
            target_q         <= RESET_PC;
            if_valid_q       <= 1'b0;
            if_pc_4_q        <= '0;
            if_instruction_q <= NOP_WORD;
        end else if (redirect_valid) begin
            if_valid_q       <= 1'b0;
            if_instruction_q <= NOP_WORD;
            // No request left in flight: jump straight to the target.
            if ((state_q == HOLD) || imem_ack) begin
                pc_q    <= redirect_pc;
                state_q <= FETCH;
            end else begin
                target_q <= redirect_pc;
                state_q  <= DRAIN;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        pc_q <= w_pc_plus4;
                        if (w_slot_free) begin
                            if_valid_q       <= 1'b1;
                            if_pc_4_q        <= w_pc_plus4;
                            if_instruction_q <= imem_rdata;
                        end else begin
                            state_q <= HOLD;
                        end
                    end else if (w_slot_free) begin
                        if_valid_q       <= 1'b0;
                        if_instruction_q <= NOP_WORD;
                    end
                end
                HOLD: begin
                    if (!id_stall) begin
                        if_valid_q       <= w_hold_valid;
                        if_pc_4_q        <= w_hold_pc_4;
                        if_instruction_q <= w_hold_data;
                        state_q          <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        pc_q    <= target_q;
                        state_q <= FETCH;
                    end
                    if (w_slot_free) begin
                        if_valid_q       <= 1'b0;
                        if_instruction_q <= NOP_WORD;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign imem_req       = !reset && (state_q != HOLD);
    assign imem_addr      = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc_4        = if_pc_4_q;
    assign if_instruction = if_instruction_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// +----------------------------------------------------------------------+
// | tb_instruction_fetch_unit: scoreboard bench for the fetch unit       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_pc_4;
    logic [31:0] if_instruction;

    logic        b_ack = 1'b0;
    logic [31:0] b_rdata = '0;
    logic        b_req;
    logic [31:0] b_addr;
    logic        b_valid;
    logic [31:0] b_pc_4;
    logic [31:0] b_instr;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0013)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc_4        (if_pc_4),
        .if_instruction (if_instruction)
    );

    instruction_fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC),
        .NOP_WORD (32'h0000_0013)
    ) dut_wrap (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (b_req),
        .imem_addr      (b_addr),
        .imem_ack       (b_ack),
        .imem_rdata     (b_rdata),
        .id_stall       (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0000_0000),
        .if_valid       (b_valid),
        .if_pc_4        (b_pc_4),
        .if_instruction (b_instr)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc4, input logic [31:0] instr);
        exp_t e;
        e.pc4   = pc4;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every instruction decode accepts must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && if_valid && !id_stall) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got pc4=%h instr=%h expected none",
                             if_pc_4, if_instruction);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc4", if_pc_4, e.pc4);
                    check("out_instr", if_instruction, e.instr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a stray ack that must be ignored
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_0000;
        #12;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_instr", if_instruction, 32'h0000_0013);
        check("rst_pc4", if_pc_4, 32'd0);
        tick();
        tick();
        reset    = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0000_0000);
        check("wrap_first_addr", b_addr, 32'hFFFF_FFFC);

        // Streaming acks at 0 and 4, no stall
        imem_ack = 1'b1; imem_rdata = 32'hA000_0000; push(32'd4, 32'hA000_0000);
        b_ack = 1'b1; b_rdata = 32'h5555_AAAA;
        tick();
        b_ack = 1'b0;
        check("wrap_valid", {31'd0, b_valid}, 32'd1);
        check("wrap_pc4", b_pc_4, 32'h0000_0000);
        check("wrap_instr", b_instr, 32'h5555_AAAA);
        check("wrap_next_addr", b_addr, 32'h0000_0000);
        check("addr_4", imem_addr, 32'd4);
        imem_rdata = 32'hA000_0004; push(32'd8, 32'hA000_0004);
        tick();
        // Ack at 8 while slot is occupied and stalled
        check("addr_8", imem_addr, 32'd8);
        imem_rdata = 32'hA000_0008; id_stall = 1'b1; push(32'd12, 32'hA000_0008);
        tick();
        imem_ack = 1'b0;
        check("hold_req", {31'd0, imem_req}, 32'd0);
        check("hold_pc4", if_pc_4, 32'd8);
        tick();
        check("hold_req2", {31'd0, imem_req}, 32'd0);
        id_stall = 1'b0;
        tick();
        check("release_req", {31'd0, imem_req}, 32'd1);
        check("release_addr", imem_addr, 32'd12);
        tick();
        // Slot drained with no new data
        check("idle_valid", {31'd0, if_valid}, 32'd0);
        check("idle_instr", if_instruction, 32'h0000_0013);
        check("idle_pc4", if_pc_4, 32'd12);
        imem_ack = 1'b1; imem_rdata = 32'hA000_000C; push(32'd16, 32'hA000_000C);
        tick();
        imem_ack = 1'b0;
        check("addr_10", imem_addr, 32'h10);
        tick();

        // Redirect while request for 0x10 is pending, ack 3 cycles later
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("drain_req", {31'd0, imem_req}, 32'd1);
        check("drain_addr", imem_addr, 32'h10);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        check("drain_valid", {31'd0, if_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h100);

        // Redirect coincident with ack
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_0100;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("redir_ack_valid", {31'd0, if_valid}, 32'd0);
        check("redir_ack_addr", imem_addr, 32'h40);
        imem_rdata = 32'hA000_0040; push(32'h44, 32'hA000_0040);
        tick();
        imem_ack = 1'b0;
        check("addr_44", imem_addr, 32'h44);
        tick();

        // Second redirect while draining overwrites the target
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h300;
        check("drain2_addr", imem_addr, 32'h44);
        tick();
        redirect_valid = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hBAD1_0044;
        tick();
        check("retarget_addr", imem_addr, 32'h300);
        check("retarget_valid", {31'd0, if_valid}, 32'd0);

        // Enter HOLD, then reset asynchronously
        imem_rdata = 32'hA000_0300;
        tick();
        id_stall = 1'b1; imem_rdata = 32'hA000_0304;
        tick();
        imem_ack = 1'b0;
        check("hold2_req", {31'd0, imem_req}, 32'd0);
        check("hold2_pc4", if_pc_4, 32'h304);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", {31'd0, if_valid}, 32'd0);
        check("async_instr", if_instruction, 32'h0000_0013);
        check("async_req", {31'd0, imem_req}, 32'd0);
        id_stall = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, 32'h0000_0000);
        tick();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
